// File: rtl/mem_board.sv
// Board side of the memory card game: layout, cursor, card reveal strobes,
// verdict handling (match/mismatch with hold), player turns, scores and result.
module mem_board #(
    parameter logic [63:0] LAYOUT      = 64'h7654_3210_0123_4567,
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic        clk_i,
    input  logic        rst,
    input  logic        move_i,
    input  logic        pick_i,
    input  logic        res_valid_i,
    input  logic        res_match_i,
    output logic [3:0]  cursor_o,
    output logic        pick_valid_o,
    output logic [3:0]  pick_idx_o,
    output logic [3:0]  pick_val_o,
    output logic        pick_second_o,
    output logic        avail_o,
    output logic [15:0] face_up_o,
    output logic [15:0] matched_o,
    output logic        player_o,
    output logic [3:0]  score0_o,
    output logic [3:0]  score1_o,
    output logic        busy_o,
    output logic [1:0]  result_o
);

    localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {StFirst, StSecond, StWaitRes, StShow, StDone} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cursor_q, cursor_d;
    logic [15:0]     face_up_q, face_up_d;
    logic [15:0]     matched_q, matched_d;
    logic            player_q, player_d;
    logic [3:0]      score0_q, score0_d;
    logic [3:0]      score1_q, score1_d;
    logic            pick_valid_q, pick_valid_d;
    logic            pick_second_q, pick_second_d;
    logic [3:0]      pick_idx_q, pick_idx_d;
    logic [3:0]      pick_val_q, pick_val_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      result_q, result_d;
    logic [3:0]      first_q, first_d;
    logic [3:0]      second_q, second_d;

    logic        avail;
    logic [3:0]  cur_val;
    logic [15:0] pair_mask;

    assign avail     = !face_up_q[cursor_q] && !matched_q[cursor_q];
    assign cur_val   = LAYOUT[{cursor_q, 2'b00} +: 4];
    assign pair_mask = (16'h0001 << first_q) | (16'h0001 << second_q);

    always_comb begin
        state_d       = state_q;
        cursor_d      = cursor_q;
        face_up_d     = face_up_q;
        matched_d     = matched_q;
        player_d      = player_q;
        score0_d      = score0_q;
        score1_d      = score1_q;
        pick_valid_d  = 1'b0;
        pick_second_d = pick_second_q;
        pick_idx_d    = pick_idx_q;
        pick_val_d    = pick_val_q;
        cnt_d         = cnt_q;
        result_d      = result_q;
        first_d       = first_q;
        second_d      = second_q;

        // The pick below uses the pre-move cursor.
        if (move_i && state_q != StDone) begin
            cursor_d = cursor_q + 4'd1;
        end

        unique case (state_q)
            StFirst, StSecond: begin
                if (pick_i && avail) begin
                    face_up_d[cursor_q] = 1'b1;
                    pick_valid_d        = 1'b1;
                    pick_idx_d          = cursor_q;
                    pick_val_d          = cur_val;
                    if (state_q == StFirst) begin
                        first_d       = cursor_q;
                        pick_second_d = 1'b0;
                        state_d       = StSecond;
                    end else begin
                        second_d      = cursor_q;
                        pick_second_d = 1'b1;
                        state_d       = StWaitRes;
                    end
                end
            end
            StWaitRes: begin
                if (res_valid_i) begin
                    if (res_match_i) begin
                        matched_d = matched_q | pair_mask;
                        face_up_d = face_up_q & ~pair_mask;
                        if (player_q) score1_d = score1_q + 4'd1;
                        else          score0_d = score0_q + 4'd1;
                        if (&matched_d) begin
                            state_d = StDone;
                            if (score0_d > score1_d)      result_d = 2'b01;
                            else if (score1_d > score0_d) result_d = 2'b10;
                            else                          result_d = 2'b11;
                        end else begin
                            state_d = StFirst;
                        end
                    end else begin
                        cnt_d   = CntW'(HOLD_CYCLES - 1);
                        state_d = StShow;
                    end
                end
            end
            StShow: begin
                if (cnt_q == '0) begin
                    face_up_d = face_up_q & ~pair_mask;
                    player_d  = ~player_q;
                    state_d   = StFirst;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: ;
            default: state_d = StFirst;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_q       <= StFirst;
            cursor_q      <= '0;
            face_up_q     <= '0;
            matched_q     <= '0;
            player_q      <= 1'b0;
            score0_q      <= '0;
            score1_q      <= '0;
            pick_valid_q  <= 1'b0;
            pick_second_q <= 1'b0;
            pick_idx_q    <= '0;
            pick_val_q    <= '0;
            cnt_q         <= '0;
            result_q      <= '0;
            first_q       <= '0;
            second_q      <= '0;
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            face_up_q     <= face_up_d;
            matched_q     <= matched_d;
            player_q      <= player_d;
            score0_q      <= score0_d;
            score1_q      <= score1_d;
            pick_valid_q  <= pick_valid_d;
            pick_second_q <= pick_second_d;
            pick_idx_q    <= pick_idx_d;
            pick_val_q    <= pick_val_d;
            cnt_q         <= cnt_d;
            result_q      <= result_d;
            first_q       <= first_d;
            second_q      <= second_d;
        end
    end

    assign cursor_o      = cursor_q;
    assign pick_valid_o  = pick_valid_q;
    assign pick_idx_o    = pick_idx_q;
    assign pick_val_o    = pick_val_q;
    assign pick_second_o = pick_second_q;
    assign avail_o       = avail;
    assign face_up_o     = face_up_q;
    assign matched_o     = matched_q;
    assign player_o      = player_q;
    assign score0_o      = score0_q;
    assign score1_o      = score1_q;
    assign busy_o        = (state_q == StWaitRes) || (state_q == StShow);
    assign result_o      = result_q;

endmodule

// File: tb/tb_mem_board.sv
// Directed bench for mem_board with a short hold time; expected values are
// hand-derived from the default layout (card i and card 15-i form a pair).
module tb_mem_board;

    localparam int unsigned Hold = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        move = 1'b0;
    logic        pick = 1'b0;
    logic        res_valid = 1'b0;
    logic        res_match = 1'b0;
    logic [3:0]  cursor;
    logic        pick_valid;
    logic [3:0]  pick_idx;
    logic [3:0]  pick_val;
    logic        pick_second;
    logic        avail;
    logic [15:0] face_up;
    logic [15:0] matched;
    logic        player;
    logic [3:0]  score0;
    logic [3:0]  score1;
    logic        busy;
    logic [1:0]  result;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] cur = 4'd0;

    mem_board #(
        .LAYOUT     (64'h7654_3210_0123_4567),
        .HOLD_CYCLES(Hold)
    ) dut (
        .clk_i        (clk),
        .rst          (rst),
        .move_i       (move),
        .pick_i       (pick),
        .res_valid_i  (res_valid),
        .res_match_i  (res_match),
        .cursor_o     (cursor),
        .pick_valid_o (pick_valid),
        .pick_idx_o   (pick_idx),
        .pick_val_o   (pick_val),
        .pick_second_o(pick_second),
        .avail_o      (avail),
        .face_up_o    (face_up),
        .matched_o    (matched),
        .player_o     (player),
        .score0_o     (score0),
        .score1_o     (score1),
        .busy_o       (busy),
        .result_o     (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Layout 64'h7654_3210_0123_4567 read nibble by nibble from the bottom.
    function automatic logic [3:0] val_of(input logic [3:0] i);
        return (i < 4'd8) ? 4'(7 - int'(i)) : 4'(int'(i) - 8);
    endfunction

    task automatic apply_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        cur = 4'd0;
    endtask

    task automatic move_to(input logic [3:0] idx);
        logic [3:0] n;
        n = idx - cur;
        for (int k = 0; k < int'(n); k++) begin
            move = 1'b1;
            step();
            move = 1'b0;
        end
        cur = idx;
    endtask

    task automatic pick_at(input logic [3:0] idx, input logic sec);
        move_to(idx);
        pick = 1'b1;
        step();
        pick = 1'b0;
        check("pick_valid", 32'(pick_valid), 32'd1);
        check("pick_idx", 32'(pick_idx), 32'(idx));
        check("pick_val", 32'(pick_val), 32'(val_of(idx)));
        check("pick_second", 32'(pick_second), 32'(sec));
    endtask

    task automatic verdict(input logic m);
        res_valid = 1'b1;
        res_match = m;
        step();
        res_valid = 1'b0;
        res_match = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            step();
        end
        check("hold_done", 32'(busy), 32'd0);
    endtask

    task automatic play(input logic [3:0] a, input logic [3:0] b, input logic m);
        pick_at(a, 1'b0);
        pick_at(b, 1'b1);
        verdict(m);
        if (!m) wait_idle();
    endtask

    initial begin
        // Reset values, checked while held and after release.
        step();
        check("rst_hold_face", 32'(face_up), 32'd0);
        apply_reset();
        step();
        check("rst_cursor", 32'(cursor), 32'd0);
        check("rst_face", 32'(face_up), 32'd0);
        check("rst_matched", 32'(matched), 32'd0);
        check("rst_player", 32'(player), 32'd0);
        check("rst_scores", 32'({score0, score1}), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_pv", 32'(pick_valid), 32'd0);
        check("rst_avail", 32'(avail), 32'd1);

        // Match path 0 / 15.
        pick_at(4'd0, 1'b0);
        move_to(4'd15);
        check("cursor15", 32'(cursor), 32'd15);
        pick_at(4'd15, 1'b1);
        check("busy_wait", 32'(busy), 32'd1);
        verdict(1'b1);
        check("m_matched", 32'(matched), 32'h8001);
        check("m_face", 32'(face_up), 32'd0);
        check("m_score0", 32'(score0), 32'd1);
        check("m_player", 32'(player), 32'd0);
        verdict(1'b1);
        check("idle_res_matched", 32'(matched), 32'h8001);
        check("idle_res_score", 32'(score0), 32'd1);
        check("avail_matched", 32'(avail), 32'd0);
        pick = 1'b1;
        step();
        pick = 1'b0;
        check("pick_matched_pv", 32'(pick_valid), 32'd0);

        // Mismatch path with re-pick and pick during hold.
        apply_reset();
        pick_at(4'd0, 1'b0);
        pick = 1'b1;
        step();
        pick = 1'b0;
        check("repick_pv", 32'(pick_valid), 32'd0);
        pick_at(4'd1, 1'b1);
        verdict(1'b0);
        check("show_face0", 32'(face_up), 32'h0003);
        pick = 1'b1;
        step();
        pick = 1'b0;
        check("show_pick_pv", 32'(pick_valid), 32'd0);
        check("show_face1", 32'(face_up), 32'h0003);
        step();
        check("show_face2", 32'(face_up), 32'h0003);
        step();
        check("show_face3", 32'(face_up), 32'h0003);
        check("show_player", 32'(player), 32'd0);
        step();
        check("show_cleared", 32'(face_up), 32'd0);
        check("show_toggle", 32'(player), 32'd1);
        check("show_busy", 32'(busy), 32'd0);

        // Simultaneous move and pick at cursor 15 wraps.
        move_to(4'd15);
        move = 1'b1;
        pick = 1'b1;
        step();
        move = 1'b0;
        pick = 1'b0;
        cur  = 4'd0;
        check("wrap_pv", 32'(pick_valid), 32'd1);
        check("wrap_idx", 32'(pick_idx), 32'd15);
        check("wrap_cursor", 32'(cursor), 32'd0);
        pick_at(4'd0, 1'b1);
        verdict(1'b1);
        check("p1_score1", 32'(score1), 32'd1);
        check("p1_score0", 32'(score0), 32'd0);
        check("p1_player", 32'(player), 32'd1);

        // Full game: 5-3 for player 0.
        apply_reset();
        for (int k = 0; k < 5; k++) play(4'(k), 4'(15 - k), 1'b1);
        play(4'd5, 4'd6, 1'b0);
        check("g1_player", 32'(player), 32'd1);
        for (int k = 5; k < 7; k++) play(4'(k), 4'(15 - k), 1'b1);
        check("g1_result_mid", 32'(result), 32'd0);
        play(4'd7, 4'd8, 1'b1);
        check("g1_result", 32'(result), 32'd1);
        check("g1_scores", 32'({score0, score1}), 32'h53);
        check("g1_matched", 32'(matched), 32'hffff);
        move = 1'b1;
        pick = 1'b1;
        step();
        move = 1'b0;
        pick = 1'b0;
        check("done_cursor", 32'(cursor), 32'd8);
        check("done_pv", 32'(pick_valid), 32'd0);
        verdict(1'b1);
        check("done_scores", 32'({score0, score1}), 32'h53);

        // Full game: 4-4 tie.
        apply_reset();
        for (int k = 0; k < 4; k++) play(4'(k), 4'(15 - k), 1'b1);
        play(4'd4, 4'd5, 1'b0);
        for (int k = 4; k < 8; k++) play(4'(k), 4'(15 - k), 1'b1);
        check("g2_result", 32'(result), 32'd3);
        check("g2_scores", 32'({score0, score1}), 32'h44);

        // Reset in the middle of the hold.
        apply_reset();
        pick_at(4'd0, 1'b0);
        pick_at(4'd1, 1'b1);
        verdict(1'b0);
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_face", 32'(face_up), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cursor", 32'(cursor), 32'd0);
        step();
        rst = 1'b1;
        cur = 4'd0;
        for (int i = 0; i < Hold + 2; i++) step();
        check("post_rst_face", 32'(face_up), 32'd0);
        check("post_rst_player", 32'(player), 32'd0);
        check("post_rst_pv", 32'(pick_valid), 32'd0);
        check("post_rst_result", 32'(result), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_board.md
# mem_board

Board-side controller for the memory card game. It holds the 16-card layout and the cursor, and reveals cards on player picks. It presents each pick (index and value) to the turn/scoring logic as a one-cycle strobe, then applies that logic's match/no-match verdict to the board. On a verdict it marks matched pairs, flips mismatched pairs back after a hold time, alternates players, keeps scores and declares the game result.

## Interface
- LAYOUT, 64'h7654_3210_0123_4567: card value of index i in bits [4i+3:4i]; each value 0..7 appears exactly twice
- HOLD_CYCLES, 50_000_000: cycles a mismatched pair stays face-up (≥1)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- move  in  1  single-cycle pulse: advance cursor
- pick  in  1  single-cycle pulse: pick card under cursor
- res_valid  in  1  verdict strobe from turn logic
- res_match  in  1  verdict: 1 = pair, sampled with res_valid
- cursor  out  4  current cursor index
- pick_valid  out  1  one-cycle strobe, a card was revealed
- pick_idx  out  4  index of revealed card, valid with pick_valid
- pick_val  out  4  value of revealed card, valid with pick_valid
- pick_second  out  1  1 when strobe is the second card of a turn
- avail  out  1  card under cursor is face-down and unmatched
- face_up  out  16  per-card revealed flag
- matched  out  16  per-card matched flag
- player  out  1  player on turn (0/1)
- score0, score1  out  4  pairs won per player, 0..8
- busy  out  1  1 in WAIT_RES and SHOW
- result  out  2  00 playing, 01 player0 wins, 10 player1 wins, 11 tie

## Operation
- Reset (asynchronous assert): state FIRST, cursor=0, face_up=0, matched=0, player=0, scores=0, pick_valid=0, pick_second=0, pick_idx=0, pick_val=0, hold counter=0, result=00. LAYOUT is constant and is never modified.
- avail = !face_up[cursor] && !matched[cursor], combinational.
- Cursor: move advances cursor, 15 wraps to 0. Moves are accepted in every state except DONE.
- FIRST: pick && avail -> set face_up[cursor], latch first=cursor, strobe pick with pick_second=0, go to SECOND. A pick with !avail is ignored.
- SECOND: pick && avail -> set face_up[cursor], latch second=cursor, strobe pick with pick_second=1, go to WAIT_RES. Picking the first card again is ignored, since avail=0.
- WAIT_RES: picks are ignored. On res_valid:
  - match=1: set matched[first] and matched[second], clear their face_up bits, increment the current player's score, keep the same player. If every matched bit would become 1, go to DONE; otherwise go to FIRST.
  - match=0: load hold counter with HOLD_CYCLES-1 and go to SHOW.
- res_valid outside WAIT_RES is ignored.
- SHOW: picks are ignored and the counter decrements each cycle. On the cycle the counter is 0: clear face_up[first] and face_up[second], toggle player, go to FIRST.
- DONE: result=01 if score0>score1, 10 if score1>score0, 11 if equal. Every input except rst is ignored; only reset leaves DONE.
- Score arithmetic is 4-bit unsigned and cannot exceed 8.

## Timing
- All outputs are registered except avail.
- Pick strobe timing: a pick sampled at edge N gives pick_valid high for exactly the cycle after edge N, with face_up updated at the same edge.
- Simultaneous move and pick: the pick uses the pre-move cursor and the cursor advances at the same edge.
- Verdict timing: res_valid at edge N updates matched, scores and state at edge N.
- A verdict may arrive in the same cycle pick_valid is high, i.e. zero-latency turn logic; it must be accepted.
- Mismatch hold: with the verdict at edge N, face_up clears and player toggles at edge N+HOLD_CYCLES.
- result becomes nonzero on the cycle after the final match verdict.
- Reset mid-SHOW or mid-WAIT_RES: the board returns immediately to the reset values. No stale pick_valid or verdict effect appears after rst releases.

## Test plan
- Reset values: hold rst low, then release -> cursor=0, face_up=0, matched=0, player=0, scores=0, result=00, pick_valid=0.
- Match path, default LAYOUT: pick idx 0, move ×15 to idx 15, pick, res_valid with res_match=1 ->
  - strobes (0,7,second=0) then (15,7,second=1)
  - matched=16'h8001, face_up=0, score0=1, player stays 0
- Mismatch path, HOLD_CYCLES=4: pick idx 0, pick idx 1, verdict 0 -> face_up=16'h0003 for exactly 4 cycles, then 0, and player=1.
- Ignored picks:
  - re-pick idx 0 while in SECOND -> no strobe
  - pick a matched card -> no strobe
  - pick during SHOW -> no strobe
  - res_valid while in FIRST -> no change
- Cursor wrap with simultaneous move and pick at cursor=15 -> strobe idx 15, cursor=0.
- Full game:
  - player0 wins 5 pairs, player1 wins 3 -> result=01 after the 8th match, and further picks and moves are ignored.
  - 4-4 split -> result=11.
  - rst asserted mid-SHOW -> all reset values restored.
